wbu: RTL and testbench

Writeback unit: the write side feeding the NPC integer register file. It accepts results from the EXU (single-cycle ops) and the LSU (multi-cycle load returns), arbitrates between them with a starvation guard, and registers exactly one write per cycle onto the register file's `rd` / `wdata` / `wen` port. It also keeps a per-register pending-write scoreboard for the IDU's hazard check.

---
 rtl/npc_wbu_pkg.sv | 17 +
 rtl/wbu_arb.sv | 52 +++++
 rtl/wbu.sv | 99 +++++++++
 tb/tb_wbu.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/npc_wbu_pkg.sv
// Shared types and constants for the writeback unit: grant source encoding,
// default starvation limit and the register-count helper.
package npc_wbu_pkg;

  localparam int STARVE_LIMIT_DEF = 3;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_EXU  = 2'd1,
    SRC_LSU  = 2'd2
  } wb_src_e;

  function automatic int nreg(input int addr_width);
    return 1 << addr_width;
  endfunction

endpackage

// File: rtl/wbu_arb.sv
// Writeback arbiter: LSU has priority, but an EXU that has lost STARVE_LIMIT
// times in a row is forced through. Readies depend only on valids and starve.
module wbu_arb
  import npc_wbu_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    exu_valid,
  input  logic    lsu_valid,
  output wb_src_e grant,
  output logic    exu_ready,
  output logic    lsu_ready
);

  localparam logic [1:0] LIMIT = 2'(STARVE_LIMIT);

  logic [1:0] starve_q, starve_d;

  always_comb begin
    grant = SRC_NONE;
    if (!rst) begin
      if (exu_valid && (!lsu_valid || starve_q == LIMIT)) begin
        grant = SRC_EXU;
      end else if (lsu_valid) begin
        grant = SRC_LSU;
      end
    end
  end

  assign exu_ready = (grant == SRC_EXU);
  assign lsu_ready = (grant == SRC_LSU);

  // Count only cycles where the EXU was waiting and lost to the LSU.
  always_comb begin
    if (grant == SRC_EXU || !exu_valid) begin
      starve_d = 2'd0;
    end else begin
      starve_d = starve_q + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= 2'd0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/wbu.sv
// Writeback unit top: registers one register-file write per cycle from the
// arbitrated EXU/LSU channel and tracks outstanding writes per register.
module wbu
  import npc_wbu_pkg::*;
#(
  parameter int ADDR_WIDTH   = 5,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
  localparam int NREG        = nreg(ADDR_WIDTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  input  logic                  exu_valid,
  output logic                  exu_ready,
  input  logic [ADDR_WIDTH-1:0] exu_rd,
  input  logic [DATA_WIDTH-1:0] exu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_rd,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  rf_wen,
  output logic [ADDR_WIDTH-1:0] rf_rd,
  output logic [DATA_WIDTH-1:0] rf_wdata,
  output logic [NREG-1:0]       busy
);

  wb_src_e grant;

  logic                  rf_wen_q, rf_wen_d;
  logic [ADDR_WIDTH-1:0] rf_rd_q, rf_rd_d;
  logic [DATA_WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]       busy_q, busy_d;

  wbu_arb #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .exu_valid(exu_valid),
    .lsu_valid(lsu_valid),
    .grant    (grant),
    .exu_ready(exu_ready),
    .lsu_ready(lsu_ready)
  );

  // Writes to x0 are consumed but never reach the register file.
  always_comb begin
    rf_wen_d   = 1'b0;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    case (grant)
      SRC_EXU: begin
        rf_wen_d   = (exu_rd != '0);
        rf_rd_d    = exu_rd;
        rf_wdata_d = exu_data;
      end
      SRC_LSU: begin
        rf_wen_d   = (lsu_rd != '0);
        rf_rd_d    = lsu_rd;
        rf_wdata_d = lsu_data;
      end
      default: ;
    endcase
  end

  // Clear applied first so a same-cycle issue to the same register wins.
  always_comb begin
    busy_d = busy_q;
    if (rf_wen_q) begin
      busy_d[rf_rd_q] = 1'b0;
    end
    if (iss_valid && iss_rd != '0) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wen_q   <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      busy_q     <= '0;
    end else begin
      rf_wen_q   <= rf_wen_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      busy_q     <= busy_d;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_wbu.sv
// Bench for wbu: directed scenarios with literal expectations, then random
// traffic checked every cycle against a behavioural writeback model.
module tb_wbu;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int NR    = 32;
  localparam int LIMIT = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_valid;
  logic [AW-1:0] iss_rd;
  logic          exu_valid, exu_ready;
  logic [AW-1:0] exu_rd;
  logic [DW-1:0] exu_data;
  logic          lsu_valid, lsu_ready;
  logic [AW-1:0] lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          rf_wen;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [NR-1:0] busy;

  always #5 clk = ~clk;

  wbu dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .exu_valid(exu_valid), .exu_ready(exu_ready), .exu_rd(exu_rd), .exu_data(exu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .busy(busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Behavioural model: state as seen during the current cycle.
  logic          m_wen   = 1'b0;
  logic [AW-1:0] m_rd    = '0;
  logic [DW-1:0] m_wdata = '0;
  logic [NR-1:0] m_busy  = '0;
  logic [DW-1:0] m_rf [NR];
  int            losses  = 0;
  int            g_exp   = 0;   // 0 none, 1 EXU, 2 LSU
  bit            chk_en  = 1'b0;

  initial begin
    for (int r = 0; r < NR; r++) m_rf[r] = '0;
    forever begin : model
      int g;
      @(negedge clk);
      g = 0;
      if (!rst) begin
        if (exu_valid && lsu_valid) g = (losses >= LIMIT) ? 1 : 2;
        else if (exu_valid)         g = 1;
        else if (lsu_valid)         g = 2;
      end
      if (chk_en) begin
        check("exu_ready", exu_ready, g == 1);
        check("lsu_ready", lsu_ready, g == 2);
        check("rf_wen",    rf_wen,    m_wen);
        check("rf_rd",     rf_rd,     m_rd);
        check("rf_wdata",  rf_wdata,  m_wdata);
        check("busy",      busy,      m_busy);
      end
      g_exp = g;
      if (rst) begin
        m_wen = 1'b0; m_rd = '0; m_wdata = '0; m_busy = '0; losses = 0;
      end else begin
        if (m_wen) begin
          m_rf[m_rd]   = m_wdata;
          m_busy[m_rd] = 1'b0;
        end
        if (iss_valid && iss_rd != 0) m_busy[iss_rd] = 1'b1;
        if (g == 1) begin
          m_wen = (exu_rd != 0); m_rd = exu_rd; m_wdata = exu_data;
        end else if (g == 2) begin
          m_wen = (lsu_rd != 0); m_rd = lsu_rd; m_wdata = lsu_data;
        end else begin
          m_wen = 1'b0;
        end
        losses = (g == 1 || !exu_valid) ? 0 : losses + 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    string  seq;
    byte    gl;

    rst = 1'b1; iss_valid = 1'b0; iss_rd = '0;
    exu_valid = 1'b1; exu_rd = 5'd3; exu_data = 32'h0000_0033;
    lsu_valid = 1'b1; lsu_rd = 5'd4; lsu_data = 32'h0000_0044;

    // Reset with both channels valid
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_wen",       rf_wen,    1'b0);
    check("rst_busy",      busy,      32'h0);
    check("rst_exu_ready", exu_ready, 1'b0);
    check("rst_lsu_ready", lsu_ready, 1'b0);
    tick();
    rst = 1'b0; lsu_rd = 5'd0;
    @(negedge clk);
    check("post_rst_lsu_ready", lsu_ready, 1'b1);
    check("post_rst_exu_ready", exu_ready, 1'b0);
    tick();
    exu_valid = 1'b0; lsu_valid = 1'b0;

    // Single EXU write to x5
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'hDEAD_BEEF;
    @(negedge clk);
    check("x5_busy_set", busy[5],   1'b1);
    check("x5_ready",    exu_ready, 1'b1);
    tick();
    exu_valid = 1'b0;
    @(negedge clk);
    check("x5_wen",      rf_wen,   1'b1);
    check("x5_rd",       rf_rd,    5'd5);
    check("x5_wdata",    rf_wdata, 32'hDEAD_BEEF);
    check("x5_busy_hold", busy[5], 1'b1);
    tick();
    @(negedge clk);
    check("x5_busy_clr", busy[5], 1'b0);
    check("x5_rf_read",  m_rf[5], 32'hDEAD_BEEF);
    tick();

    // Contention: both valid for 8 cycles
    exu_valid = 1'b1; exu_rd = 5'd1; exu_data = 32'h1111_1111;
    lsu_valid = 1'b1; lsu_rd = 5'd2; lsu_data = 32'h2222_2222;
    seq = "LLLELLLE";
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      gl = exu_ready ? "E" : (lsu_ready ? "L" : "-");
      check($sformatf("contention_gnt%0d", i), gl, seq[i]);
      tick();
    end
    exu_valid = 1'b0; lsu_valid = 1'b0;

    // x0 write and x0 issue
    exu_valid = 1'b1; exu_rd = 5'd0; exu_data = 32'h0000_1234;
    iss_valid = 1'b1; iss_rd = 5'd0;
    @(negedge clk);
    check("x0_ready", exu_ready, 1'b1);
    tick();
    exu_valid = 1'b0; iss_valid = 1'b0;
    @(negedge clk);
    check("x0_wen",   rf_wen,   1'b0);
    check("x0_rd",    rf_rd,    5'd0);
    check("x0_wdata", rf_wdata, 32'h0000_1234);
    check("x0_busy",  busy[0],  1'b0);
    tick();

    // Set/clear collision on x7
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    iss_valid = 1'b0;
    exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'hCAFE_0007;
    tick();
    exu_valid = 1'b0;
    iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    check("coll_wen", rf_wen, 1'b1);
    check("coll_rd",  rf_rd,  5'd7);
    tick();
    iss_valid = 1'b0;
    @(negedge clk);
    check("coll_busy7", busy[7], 1'b1);

    // Reset mid-stream drops the pending write
    tick();
    lsu_valid = 1'b1; lsu_rd = 5'd9; lsu_data = 32'h0000_0099;
    tick();
    lsu_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("mid_wen_before", rf_wen, 1'b1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_wen_after",  rf_wen, 1'b0);
    check("mid_busy_after", busy,   32'h0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      tick();
      if (!exu_valid || g_exp == 1) begin
        exu_valid = ($urandom_range(99) < 60);
        exu_rd    = 5'($urandom_range(31));
        exu_data  = $urandom;
      end
      if (!lsu_valid || g_exp == 2) begin
        lsu_valid = ($urandom_range(99) < 60);
        lsu_rd    = 5'($urandom_range(31));
        lsu_data  = $urandom;
      end
      r = $urandom_range(31);
      iss_rd    = 5'(r);
      iss_valid = ($urandom_range(99) < 40) && !m_busy[r];
      rst       = ($urandom_range(299) == 0);
    end
    tick();
    rst = 1'b0; exu_valid = 1'b0; lsu_valid = 1'b0; iss_valid = 1'b0;
    tick();
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
